// File: rtl/banzai_pkg.sv
// rtl/banzai_pkg.sv - shared types and register map for the Bayesian-machine chip sequencer
package banzai_pkg;

    typedef enum logic [3:0] {
        ST_OFF    = 4'd0,
        ST_PWR_UP = 4'd1,
        ST_RST    = 4'd2,
        ST_IDLE   = 4'd3,
        ST_RUN    = 4'd4
    } chan_state_e;

    localparam logic [2:0] REG_PWR_EN   = 3'd0;
    localparam logic [2:0] REG_START    = 3'd1;
    localparam logic [2:0] REG_STATUS   = 3'd2;
    localparam logic [2:0] REG_ERR      = 3'd3;
    localparam logic [2:0] REG_TIMEOUT  = 3'd4;
    localparam logic [2:0] REG_DONE_STS = 3'd5;
    localparam logic [2:0] REG_IRQ_EN   = 3'd6;

    localparam int IRQ_EN_DONE = 0;
    localparam int IRQ_EN_ERR  = 1;

endpackage

// File: rtl/banzai_chan_fsm.sv
// rtl/banzai_chan_fsm.sv - one chip channel: power/reset sequencing, run timeout, start/done handling
module banzai_chan_fsm
    import banzai_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int PWR_DLY = 64,
    parameter int RST_CYC = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwr_en_i,
    input  logic             start_i,
    input  logic             chip_done_i,
    input  logic [CNT_W-1:0] timeout_i,
    output logic [3:0]       state_o,
    output logic             chip_pwr_en_o,
    output logic             chip_rst_n_o,
    output logic             chip_start_o,
    output logic             done_set_o,
    output logic             err_set_o
);

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_DLY - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYC - 1);

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, start_d;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W-1:0] cnt_sat;
    logic             timed_out;

    // Compare the post-increment count so the timeout lands after exactly TIMEOUT run cycles.
    assign cnt_inc   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign cnt_sat   = (&cnt_q) ? cnt_q : cnt_inc[CNT_W-1:0];
    assign timed_out = (timeout_i != '0) && (cnt_inc >= {1'b0, timeout_i});

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        start_d    = 1'b0;
        done_set_o = 1'b0;
        err_set_o  = 1'b0;
        if (!pwr_en_i) begin
            state_d = ST_OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_PWR_UP;
                    cnt_d   = '0;
                end
                ST_PWR_UP: begin
                    if (cnt_q >= PWR_LAST) begin
                        state_d = ST_RST;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_sat;
                    end
                end
                ST_RST: begin
                    if (cnt_q >= RST_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_sat;
                    end
                end
                ST_IDLE: begin
                    if (start_i) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        start_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    // Done outranks a timeout landing in the same cycle.
                    if (chip_done_i) begin
                        state_d    = ST_IDLE;
                        done_set_o = 1'b1;
                    end else if (timed_out) begin
                        state_d   = ST_RST;
                        cnt_d     = '0;
                        err_set_o = 1'b1;
                    end else begin
                        cnt_d = cnt_sat;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
        end
    end

    assign state_o       = state_q;
    assign chip_pwr_en_o = (state_q != ST_OFF);
    assign chip_rst_n_o  = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign chip_start_o  = start_q;

endmodule

// File: rtl/banzai_chip_seq.sv
// rtl/banzai_chip_seq.sv - N-channel Bayesian-machine chip sequencer with register file and irq
module banzai_chip_seq
    import banzai_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 16,
    parameter int PWR_DLY = 64,
    parameter int RST_CYC = 8,
    parameter int TO_DEF  = 1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            reg_req,
    input  logic            reg_we,
    input  logic [2:0]      reg_addr,
    input  logic [31:0]     reg_wdata,
    output logic            reg_gnt,
    output logic            reg_rvalid,
    output logic [31:0]     reg_rdata,
    output logic            reg_err,
    output logic [N_CH-1:0] chip_pwr_en,
    output logic [N_CH-1:0] chip_rst_n,
    output logic [N_CH-1:0] chip_start,
    input  logic [N_CH-1:0] chip_done,
    output logic            irq
);

    logic [N_CH-1:0]   pwr_en_q, pwr_en_d;
    logic [N_CH-1:0]   err_q, err_d;
    logic [N_CH-1:0]   done_q, done_d;
    logic [CNT_W-1:0]  timeout_q, timeout_d;
    logic [1:0]        irq_en_q, irq_en_d;
    logic              irq_q, irq_d;
    logic              rvalid_q;
    logic [31:0]       rdata_q, rdata_d;
    logic              rerr_q, rerr_d;

    logic              wr;
    logic [N_CH-1:0]   start_bits, err_clr, done_clr, err_set, done_set;
    logic [4*N_CH-1:0] status_vec;
    logic              unused_wdata;

    assign wr           = reg_req && reg_we;
    assign unused_wdata = ^reg_wdata;

    // Channels see the incoming PWR_EN value so power changes act at the write edge.
    assign pwr_en_d   = (wr && reg_addr == REG_PWR_EN)  ? reg_wdata[N_CH-1:0]  : pwr_en_q;
    assign timeout_d  = (wr && reg_addr == REG_TIMEOUT) ? reg_wdata[CNT_W-1:0] : timeout_q;
    assign irq_en_d   = (wr && reg_addr == REG_IRQ_EN)  ? reg_wdata[1:0]       : irq_en_q;
    assign start_bits = (wr && reg_addr == REG_START)    ? reg_wdata[N_CH-1:0] : '0;
    assign err_clr    = (wr && reg_addr == REG_ERR)      ? reg_wdata[N_CH-1:0] : '0;
    assign done_clr   = (wr && reg_addr == REG_DONE_STS) ? reg_wdata[N_CH-1:0] : '0;

    assign err_d  = (err_q  & ~err_clr)  | err_set;
    assign done_d = (done_q & ~done_clr) | done_set;
    assign irq_d  = (irq_en_q[IRQ_EN_DONE] & (|done_q)) | (irq_en_q[IRQ_EN_ERR] & (|err_q));

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        banzai_chan_fsm #(
            .CNT_W  (CNT_W),
            .PWR_DLY(PWR_DLY),
            .RST_CYC(RST_CYC)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .pwr_en_i     (pwr_en_d[g]),
            .start_i      (start_bits[g]),
            .chip_done_i  (chip_done[g]),
            .timeout_i    (timeout_q),
            .state_o      (status_vec[4*g +: 4]),
            .chip_pwr_en_o(chip_pwr_en[g]),
            .chip_rst_n_o (chip_rst_n[g]),
            .chip_start_o (chip_start[g]),
            .done_set_o   (done_set[g]),
            .err_set_o    (err_set[g])
        );
    end

    always_comb begin
        rdata_d = '0;
        rerr_d  = reg_req && (reg_addr > REG_IRQ_EN);
        if (reg_req && !reg_we) begin
            case (reg_addr)
                REG_PWR_EN:   rdata_d = 32'(pwr_en_q);
                REG_STATUS:   rdata_d = 32'(status_vec);
                REG_ERR:      rdata_d = 32'(err_q);
                REG_TIMEOUT:  rdata_d = 32'(timeout_q);
                REG_DONE_STS: rdata_d = 32'(done_q);
                REG_IRQ_EN:   rdata_d = 32'(irq_en_q);
                default:      rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwr_en_q  <= '0;
            err_q     <= '0;
            done_q    <= '0;
            timeout_q <= CNT_W'(TO_DEF);
            irq_en_q  <= '0;
            irq_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rerr_q    <= 1'b0;
        end else begin
            pwr_en_q  <= pwr_en_d;
            err_q     <= err_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
            rvalid_q  <= reg_req;
            rdata_q   <= rdata_d;
            rerr_q    <= rerr_d;
        end
    end

    assign reg_gnt    = 1'b1;
    assign reg_rvalid = rvalid_q;
    assign reg_rdata  = rdata_q;
    assign reg_err    = rerr_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_banzai_chip_seq.sv
// tb/tb_banzai_chip_seq.sv - self-checking bench for banzai_chip_seq
module tb_banzai_chip_seq;

    localparam int N_CH    = 4;
    localparam int CNT_W   = 16;
    localparam int PWR_DLY = 64;
    localparam int RST_CYC = 8;
    localparam int TO_DEF  = 1000;

    localparam logic [2:0] A_PWR_EN = 3'd0, A_START = 3'd1, A_STATUS = 3'd2, A_ERR = 3'd3;
    localparam logic [2:0] A_TIMEOUT = 3'd4, A_DONE = 3'd5, A_IRQ_EN = 3'd6, A_BAD = 3'd7;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            reg_req;
    logic            reg_we;
    logic [2:0]      reg_addr;
    logic [31:0]     reg_wdata;
    logic            reg_gnt;
    logic            reg_rvalid;
    logic [31:0]     reg_rdata;
    logic            reg_err;
    logic [N_CH-1:0] chip_pwr_en;
    logic [N_CH-1:0] chip_rst_n;
    logic [N_CH-1:0] chip_start;
    logic [N_CH-1:0] chip_done;
    logic            irq;

    int passed = 0;
    int total  = 0;

    banzai_chip_seq #(
        .N_CH(N_CH), .CNT_W(CNT_W), .PWR_DLY(PWR_DLY), .RST_CYC(RST_CYC), .TO_DEF(TO_DEF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_gnt(reg_gnt), .reg_rvalid(reg_rvalid), .reg_rdata(reg_rdata),
        .reg_err(reg_err), .chip_pwr_en(chip_pwr_en), .chip_rst_n(chip_rst_n),
        .chip_start(chip_start), .chip_done(chip_done), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
        reg_req = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
        tick();
        reg_req = 1'b0; reg_we = 1'b0;
    endtask

    task automatic reg_rd(input logic [2:0] a, output logic [31:0] d, output logic e, output logic v);
        reg_req = 1'b1; reg_we = 1'b0; reg_addr = a;
        tick();
        d = reg_rdata; e = reg_err; v = reg_rvalid;
        reg_req = 1'b0;
    endtask

    // One start on channel ch; tmo = TIMEOUT (0 = off); dly = RUN cycle carrying chip_done (0 = never).
    task automatic run_case(input int ch, input int tmo, input int dly, input bit clr);
        logic [31:0] rd;
        logic re, rv;
        logic exp_done, exp_err;
        int   n_start, n_low, k_fall, limit;
        exp_done = (dly != 0) && (tmo == 0 || dly <= tmo);
        exp_err  = !exp_done && (tmo != 0);
        limit    = ((dly > tmo) ? dly : tmo) + RST_CYC + 4;
        if (clr) begin
            reg_wr(A_DONE, 32'hF);
            reg_wr(A_ERR, 32'hF);
        end
        reg_wr(A_TIMEOUT, 32'(tmo));
        reg_wr(A_START, 32'(1) << ch);
        n_start = 0; n_low = 0; k_fall = 0;
        for (int k = 1; k <= limit; k++) begin
            chip_done = '0;
            if (k == dly) chip_done[ch] = 1'b1;
            if (chip_start[ch]) n_start++;
            if (!chip_rst_n[ch]) begin
                n_low++;
                if (k_fall == 0) k_fall = k;
            end
            tick();
        end
        chip_done = '0;
        total++; if (n_start !== 1) $display("FAIL run_start_width ch%0d: got %0d cycles exp 1", ch, n_start); else passed++;
        total++; if (n_low !== (exp_err ? RST_CYC : 0)) $display("FAIL run_rst_low ch%0d t=%0d d=%0d: got %0d exp %0d", ch, tmo, dly, n_low, exp_err ? RST_CYC : 0); else passed++;
        if (exp_err) begin
            total++; if (k_fall !== tmo + 1) $display("FAIL run_timeout_cycle ch%0d: got %0d exp %0d", ch, k_fall, tmo + 1); else passed++;
        end
        reg_rd(A_DONE, rd, re, rv);
        if (clr) begin
            total++; if (rd !== (32'(exp_done) << ch)) $display("FAIL run_done_sts ch%0d t=%0d d=%0d: got %0h exp %0h", ch, tmo, dly, rd, 32'(exp_done) << ch); else passed++;
        end else begin
            total++; if (rd[ch] !== exp_done) $display("FAIL run_done_bit ch%0d: got %0b exp %0b", ch, rd[ch], exp_done); else passed++;
        end
        reg_rd(A_ERR, rd, re, rv);
        if (clr) begin
            total++; if (rd !== (32'(exp_err) << ch)) $display("FAIL run_err ch%0d t=%0d d=%0d: got %0h exp %0h", ch, tmo, dly, rd, 32'(exp_err) << ch); else passed++;
        end else begin
            total++; if (rd[ch] !== exp_err) $display("FAIL run_err_bit ch%0d: got %0b exp %0b", ch, rd[ch], exp_err); else passed++;
        end
        reg_rd(A_STATUS, rd, re, rv);
        total++; if (rd[4*ch +: 4] !== 4'd3) $display("FAIL run_status_idle ch%0d: got %0h exp 3", ch, rd[4*ch +: 4]); else passed++;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic re, rv;
        rst_n = 1'b0; reg_req = 1'b0; reg_we = 1'b0; reg_addr = '0; reg_wdata = '0; chip_done = '0;
        repeat (3) tick();
        total++; if ({chip_pwr_en, chip_rst_n, chip_start, irq, reg_rvalid} !== '0) $display("FAIL reset_outputs: got %0h exp 0", {chip_pwr_en, chip_rst_n, chip_start, irq, reg_rvalid}); else passed++;
        total++; if (reg_gnt !== 1'b1) $display("FAIL reset_gnt: got %0b exp 1", reg_gnt); else passed++;
        rst_n = 1'b1;
        tick();
        total++; if (reg_rvalid !== 1'b0) $display("FAIL idle_rvalid: got %0b exp 0", reg_rvalid); else passed++;
        reg_rd(A_TIMEOUT, rd, re, rv);
        total++; if ({rv, re, rd} !== {1'b1, 1'b0, 32'(TO_DEF)}) $display("FAIL reset_timeout: got v%0b e%0b %0d exp v1 e0 %0d", rv, re, rd, TO_DEF); else passed++;
        reg_rd(A_STATUS, rd, re, rv);
        total++; if (rd !== 32'h0) $display("FAIL reset_status: got %0h exp 0", rd); else passed++;
    endtask

    task automatic test_power_up();
        logic [31:0] rd;
        logic re, rv;
        int n;
        reg_wr(A_PWR_EN, 32'h1);
        total++; if (chip_pwr_en !== 4'b0001) $display("FAIL pwrup_pwr_en: got %0b exp 0001", chip_pwr_en); else passed++;
        n = 0;
        while (!chip_rst_n[0] && n < 500) begin
            n++;
            tick();
        end
        total++; if (n !== PWR_DLY + RST_CYC) $display("FAIL pwrup_rst_low_cycles: got %0d exp %0d", n, PWR_DLY + RST_CYC); else passed++;
        reg_rd(A_STATUS, rd, re, rv);
        total++; if (rd !== 32'h3) $display("FAIL pwrup_status: got %0h exp 3", rd); else passed++;
        total++; if (chip_pwr_en[3:1] !== 3'b000) $display("FAIL pwrup_others_off: got %0b exp 000", chip_pwr_en[3:1]); else passed++;
        reg_wr(A_PWR_EN, 32'hF);
        repeat (PWR_DLY + RST_CYC + 2) tick();
        reg_rd(A_STATUS, rd, re, rv);
        total++; if (rd !== 32'h3333) $display("FAIL pwrup_all_status: got %0h exp 3333", rd); else passed++;
    endtask

    task automatic test_normal_run();
        logic [31:0] rd;
        logic re, rv;
        reg_wr(A_TIMEOUT, 32'd100);
        reg_wr(A_IRQ_EN, 32'h1);
        reg_wr(A_START, 32'h1);
        total++; if (chip_start !== 4'b0001) $display("FAIL normal_start_pulse: got %0b exp 0001", chip_start); else passed++;
        tick();
        total++; if (chip_start !== 4'b0000) $display("FAIL normal_start_width: got %0b exp 0000", chip_start); else passed++;
        repeat (9) tick();
        chip_done[0] = 1'b1;
        tick();
        chip_done = '0;
        total++; if (irq !== 1'b0) $display("FAIL normal_irq_lag: got %0b exp 0", irq); else passed++;
        tick();
        total++; if (irq !== 1'b1) $display("FAIL normal_irq_set: got %0b exp 1", irq); else passed++;
        reg_rd(A_DONE, rd, re, rv);
        total++; if (rd !== 32'h1) $display("FAIL normal_done_sts: got %0h exp 1", rd); else passed++;
        reg_wr(A_DONE, 32'h1);
        total++; if (irq !== 1'b1) $display("FAIL normal_irq_hold: got %0b exp 1", irq); else passed++;
        tick();
        total++; if (irq !== 1'b0) $display("FAIL normal_irq_clear: got %0b exp 0", irq); else passed++;
    endtask

    task automatic test_timeout();
        logic [31:0] rd;
        logic re, rv;
        reg_wr(A_IRQ_EN, 32'h2);
        run_case(1, 20, 0, 1'b1);
        total++; if (irq !== 1'b1) $display("FAIL timeout_irq: got %0b exp 1", irq); else passed++;
        repeat (5) tick();
        reg_rd(A_ERR, rd, re, rv);
        total++; if (rd !== 32'h2) $display("FAIL timeout_err_sticky: got %0h exp 2", rd); else passed++;
        reg_wr(A_ERR, 32'h2);
        tick();
        total++; if (irq !== 1'b0) $display("FAIL timeout_irq_clear: got %0b exp 0", irq); else passed++;
        reg_rd(A_ERR, rd, re, rv);
        total++; if (rd !== 32'h0) $display("FAIL timeout_err_w1c: got %0h exp 0", rd); else passed++;
        reg_wr(A_IRQ_EN, 32'h0);
        run_case(1, 15, 15, 1'b1);
    endtask

    task automatic test_power_removal();
        logic [31:0] rd;
        logic re, rv;
        run_case(2, 0, 4, 1'b1);
        run_case(3, 5, 0, 1'b0);
        reg_wr(A_TIMEOUT, 32'h0);
        reg_wr(A_START, 32'h1);
        repeat (20) tick();
        reg_rd(A_STATUS, rd, re, rv);
        total++; if (rd[3:0] !== 4'd4) $display("FAIL prm_running: got %0h exp 4", rd[3:0]); else passed++;
        reg_wr(A_PWR_EN, 32'hE);
        total++; if ({chip_pwr_en, chip_rst_n[0]} !== 5'b11100) $display("FAIL prm_pads: got %0b exp 11100", {chip_pwr_en, chip_rst_n[0]}); else passed++;
        reg_rd(A_STATUS, rd, re, rv);
        total++; if (rd !== 32'h3330) $display("FAIL prm_status: got %0h exp 3330", rd); else passed++;
        reg_rd(A_DONE, rd, re, rv);
        total++; if (rd !== 32'h4) $display("FAIL prm_done_kept: got %0h exp 4", rd); else passed++;
        reg_rd(A_ERR, rd, re, rv);
        total++; if (rd !== 32'h8) $display("FAIL prm_err_kept: got %0h exp 8", rd); else passed++;
        reg_wr(A_START, 32'h1);
        total++; if (chip_start !== 4'b0000) $display("FAIL start_off_chan: got %0b exp 0000", chip_start); else passed++;
        tick();
        total++; if ({chip_start, chip_pwr_en[0]} !== 5'b00000) $display("FAIL start_off_after: got %0b exp 00000", {chip_start, chip_pwr_en[0]}); else passed++;
        reg_wr(A_PWR_EN, 32'hF);
        repeat (PWR_DLY + RST_CYC + 2) tick();
        reg_rd(A_STATUS, rd, re, rv);
        total++; if (rd !== 32'h3333) $display("FAIL prm_restore: got %0h exp 3333", rd); else passed++;
    endtask

    task automatic test_illegal_addr();
        logic [31:0] rd;
        logic re, rv;
        reg_rd(A_BAD, rd, re, rv);
        total++; if ({rv, re, rd} !== {1'b1, 1'b1, 32'h0}) $display("FAIL bad_read: got v%0b e%0b %0h exp v1 e1 0", rv, re, rd); else passed++;
        reg_wr(A_BAD, 32'h0);
        total++; if (reg_err !== 1'b1) $display("FAIL bad_write_err: got %0b exp 1", reg_err); else passed++;
        reg_rd(A_PWR_EN, rd, re, rv);
        total++; if ({re, rd} !== {1'b0, 32'hF}) $display("FAIL bad_write_ignored: got e%0b %0h exp e0 f", re, rd); else passed++;
    endtask

    task automatic test_multi_channel();
        logic [31:0] rd;
        logic re, rv;
        reg_wr(A_DONE, 32'hF);
        reg_wr(A_ERR, 32'hF);
        reg_wr(A_TIMEOUT, 32'h0);
        reg_wr(A_START, 32'hF);
        total++; if (chip_start !== 4'hF) $display("FAIL multi_start: got %0h exp f", chip_start); else passed++;
        tick();
        total++; if (chip_start !== 4'h0) $display("FAIL multi_start_width: got %0h exp 0", chip_start); else passed++;
        for (int k = 2; k <= 10; k++) begin
            chip_done = '0;
            for (int i = 0; i < N_CH; i++) if (k == 2 + 2 * i) chip_done[i] = 1'b1;
            tick();
        end
        chip_done = '0;
        reg_rd(A_DONE, rd, re, rv);
        total++; if (rd !== 32'hF) $display("FAIL multi_done_sts: got %0h exp f", rd); else passed++;
        reg_rd(A_STATUS, rd, re, rv);
        total++; if (rd !== 32'h3333) $display("FAIL multi_status: got %0h exp 3333", rd); else passed++;
    endtask

    task automatic test_random();
        int ch, tmo, dly;
        for (int it = 0; it < 12; it++) begin
            ch  = int'($urandom_range(0, N_CH - 1));
            tmo = int'($urandom_range(3, 30));
            dly = int'($urandom_range(1, 36));
            if ($urandom_range(0, 5) == 0) tmo = 0;
            run_case(ch, tmo, dly, 1'b1);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] rd;
        logic re, rv;
        rst_n = 1'b0;
        #1;
        total++; if ({chip_pwr_en, chip_rst_n} !== 8'h00) $display("FAIL midreset_pads: got %0h exp 0", {chip_pwr_en, chip_rst_n}); else passed++;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        reg_rd(A_PWR_EN, rd, re, rv);
        total++; if (rd !== 32'h0) $display("FAIL midreset_pwr_en: got %0h exp 0", rd); else passed++;
        reg_rd(A_TIMEOUT, rd, re, rv);
        total++; if (rd !== 32'(TO_DEF)) $display("FAIL midreset_timeout: got %0d exp %0d", rd, TO_DEF); else passed++;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_normal_run();
        test_timeout();
        test_power_removal();
        test_illegal_addr();
        test_multi_channel();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
